// File: rtl/nubus_card_interface.sv
`timescale 1ns/1ps
// NuBus card interface: CPU-side master engine and slot-decoded slave engine sharing the NuBus lines.
// Latency: master >= ARB_CYCLES+2 clocks to start plus slave wait; slave adds mem wait + 1 clock ack.
// Backpressure: cpu_valid is held until the one-cycle cpu_ready; mem_valid is held until mem_ready.
//
// Ports:
//   nub_clkn/nub_resetn   NuBus clock (drive on rising, sample on falling) and async active-low reset
//   nub_idn               inverted slot id
//   nub_* inout           open-collector, active-low NuBus lines (driven 0 or released)
//   mem_*                 slave-side local memory valid/ready port
//   cpu_*                 master-side local CPU request port
module nubus_card_interface #(
   parameter int ARB_CYCLES = 2
) (
   input  logic        nub_clkn,
   input  logic        nub_resetn,
   input  logic [3:0]  nub_idn,
   input  logic        nub_pfwn,
   inout  wire  [31:0] nub_adn,
   inout  wire         nub_tm0n,
   inout  wire         nub_tm1n,
   inout  wire         nub_startn,
   inout  wire         nub_rqstn,
   inout  wire         nub_ackn,
   inout  wire  [3:0]  nub_arbn,
   inout  wire         nub_nmrqn,
   inout  wire         nub_spn,
   inout  wire         nub_spvn,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        mem_myslot,
   output logic        mem_myexp,
   input  logic        cpu_valid,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_wstrb,
   input  logic        cpu_lock,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata
);

   typedef enum logic [2:0] {M_IDLE, M_ARB, M_START, M_DATA, M_DONE} mst_state_t;
   typedef enum logic [1:0] {S_IDLE, S_WDAT, S_MEM, S_ACK} slv_state_t;

   localparam logic [7:0] ARB_LAST = 8'(ARB_CYCLES - 1);

   // start-cycle mode: {tm1, tm0, ad[1], ad[0]} in logical polarity
   function automatic logic [3:0] enc_mode(input logic [3:0] ws);
      case (ws)
         4'b0000: return 4'b0000;
         4'b0011: return 4'b1001;
         4'b1100: return 4'b1010;
         4'b0001: return 4'b1100;
         4'b0010: return 4'b1101;
         4'b0100: return 4'b1110;
         4'b1000: return 4'b1111;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [3:0] dec_strb(input logic tm1, input logic tm0, input logic [1:0] lo);
      if (!tm1) return 4'b0000;
      if (tm0)  return 4'b0001 << lo;
      case (lo)
         2'b01:   return 4'b0011;
         2'b10:   return 4'b1100;
         default: return 4'b1111;
      endcase
   endfunction

   // logical views of the bus (line low = 1)
   logic [3:0]  id;
   logic [31:0] ad_in;
   logic [3:0]  arb_in;
   logic        start_in, ack_in, tm0_in, tm1_in;
   assign id       = ~nub_idn;
   assign ad_in    = ~nub_adn;
   assign arb_in   = ~nub_arbn;
   assign start_in = ~nub_startn;
   assign ack_in   = ~nub_ackn;
   assign tm0_in   = ~nub_tm0n;
   assign tm1_in   = ~nub_tm1n;

   logic unused_ok;
   assign unused_ok = &{1'b0, nub_pfwn, nub_nmrqn, nub_spn, nub_spvn};

   // ---------------- falling-edge (sampling) state ----------------
   mst_state_t  mst_state_q, mst_state_d;
   logic [7:0]  arb_cnt_q, arb_cnt_d;
   logic        own_q, own_d;
   logic        busy_q, busy_d;
   logic [3:0]  arb_smp_q, arb_smp_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [3:0]  m_wstrb_q, m_wstrb_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;

   slv_state_t  slv_state_q, slv_state_d;
   logic        mem_valid_q, mem_valid_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_myslot_q, mem_myslot_d;
   logic        mem_myexp_q, mem_myexp_d;
   logic [31:0] s_rdata_q, s_rdata_d;

   // rising-edge (driving) state
   logic        cpu_ready_q, cpu_ready_d;
   logic [31:0] drv_ad_q, drv_ad_d;
   logic        drv_tm0_q, drv_tm0_d;
   logic        drv_tm1_q, drv_tm1_d;
   logic        drv_start_q, drv_start_d;
   logic        drv_rqst_q, drv_rqst_d;
   logic        drv_ack_q, drv_ack_d;
   logic [3:0]  drv_arb_q, drv_arb_d;

   logic bus_idle, myslot, myexp;
   assign bus_idle = !start_in && !busy_q;
   assign myslot   = (ad_in[31:24] == {4'hF, id});
   assign myexp    = (id >= 4'h9) && (id <= 4'hE) && (ad_in[31:28] == id);

   always_comb begin
      mst_state_d  = mst_state_q;
      arb_cnt_d    = arb_cnt_q;
      own_d        = own_q;
      arb_smp_d    = arb_in;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_wstrb_d    = m_wstrb_q;
      cpu_rdata_d  = cpu_rdata_q;
      // a transaction is outstanding from its start until its ack
      busy_d       = busy_q;
      if (start_in)    busy_d = 1'b1;
      else if (ack_in) busy_d = 1'b0;

      case (mst_state_q)
         M_IDLE: begin
            if (cpu_valid && !cpu_ready_q) begin
               m_addr_d  = cpu_addr;
               m_wdata_d = cpu_wdata;
               m_wstrb_d = cpu_wstrb;
               if (own_q) begin
                  // locked owner: no arbitration, just wait for a quiet bus
                  if (bus_idle) mst_state_d = M_START;
               end else begin
                  mst_state_d = M_ARB;
                  arb_cnt_d   = 8'd0;
               end
            end
         end
         M_ARB: begin
            if (arb_in == id && arb_cnt_q >= ARB_LAST && bus_idle) begin
               mst_state_d = M_START;
            end else if (arb_cnt_q != 8'hFF) begin
               arb_cnt_d = arb_cnt_q + 8'd1;
            end
         end
         M_START: mst_state_d = M_DATA;
         M_DATA: begin
            if (ack_in) begin
               if (m_wstrb_q == 4'b0000) cpu_rdata_d = ad_in;
               own_d       = cpu_lock;
               mst_state_d = M_DONE;
            end
         end
         default: mst_state_d = M_IDLE;
      endcase
   end

   always_comb begin
      slv_state_d  = slv_state_q;
      mem_valid_d  = mem_valid_q;
      mem_wstrb_d  = mem_wstrb_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_myslot_d = mem_myslot_q;
      mem_myexp_d  = mem_myexp_q;
      s_rdata_d    = s_rdata_q;
      case (slv_state_q)
         S_IDLE: begin
            if (start_in && (myslot || myexp)) begin
               mem_addr_d   = {ad_in[31:2], 2'b00};
               mem_myslot_d = myslot;
               mem_myexp_d  = myexp;
               mem_wstrb_d  = dec_strb(tm1_in, tm0_in, ad_in[1:0]);
               if (!tm1_in) begin
                  mem_valid_d = 1'b1;
                  slv_state_d = S_MEM;
               end else begin
                  slv_state_d = S_WDAT;
               end
            end
         end
         S_WDAT: begin
            mem_wdata_d = ad_in;
            mem_valid_d = 1'b1;
            slv_state_d = S_MEM;
         end
         S_MEM: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               s_rdata_d   = mem_rdata;
               slv_state_d = S_ACK;
            end
         end
         default: slv_state_d = S_IDLE;
      endcase
   end

   always_ff @(negedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         mst_state_q  <= M_IDLE;
         arb_cnt_q    <= '0;
         own_q        <= 1'b0;
         busy_q       <= 1'b0;
         arb_smp_q    <= '0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_wstrb_q    <= '0;
         cpu_rdata_q  <= '0;
         slv_state_q  <= S_IDLE;
         mem_valid_q  <= 1'b0;
         mem_wstrb_q  <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_myslot_q <= 1'b0;
         mem_myexp_q  <= 1'b0;
         s_rdata_q    <= '0;
      end else begin
         mst_state_q  <= mst_state_d;
         arb_cnt_q    <= arb_cnt_d;
         own_q        <= own_d;
         busy_q       <= busy_d;
         arb_smp_q    <= arb_smp_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_wstrb_q    <= m_wstrb_d;
         cpu_rdata_q  <= cpu_rdata_d;
         slv_state_q  <= slv_state_d;
         mem_valid_q  <= mem_valid_d;
         mem_wstrb_q  <= mem_wstrb_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_myslot_q <= mem_myslot_d;
         mem_myexp_q  <= mem_myexp_d;
         s_rdata_q    <= s_rdata_d;
      end
   end

   // ---------------- rising-edge line drivers ----------------
   logic [3:0] mode;
   logic       arb_go;
   assign mode = enc_mode(m_wstrb_q);

   always_comb begin
      cpu_ready_d = (mst_state_q == M_DONE);
      drv_start_d = (mst_state_q == M_START);
      drv_rqst_d  = (mst_state_q == M_ARB);
      drv_tm1_d   = drv_start_d && mode[3];
      drv_tm0_d   = drv_start_d && mode[2];
      drv_ack_d   = (slv_state_q == S_ACK);
      drv_ad_d    = '0;
      if (mst_state_q == M_START)
         drv_ad_d = {m_addr_q[31:2], mode[1:0]};
      else if (mst_state_q == M_DATA && m_wstrb_q != 4'b0000)
         drv_ad_d = m_wdata_q;
      if (slv_state_q == S_ACK && mem_wstrb_q == 4'b0000)
         drv_ad_d = drv_ad_d | s_rdata_q;
      // arbitration: once a higher competitor bit shows where our id has 0, back off all lower bits
      arb_go    = 1'b1;
      drv_arb_d = '0;
      for (int i = 3; i >= 0; i--) begin
         drv_arb_d[i] = drv_rqst_d && arb_go && id[i];
         if (!id[i] && arb_smp_q[i]) arb_go = 1'b0;
      end
   end

   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         cpu_ready_q <= 1'b0;
         drv_ad_q    <= '0;
         drv_tm0_q   <= 1'b0;
         drv_tm1_q   <= 1'b0;
         drv_start_q <= 1'b0;
         drv_rqst_q  <= 1'b0;
         drv_ack_q   <= 1'b0;
         drv_arb_q   <= '0;
      end else begin
         cpu_ready_q <= cpu_ready_d;
         drv_ad_q    <= drv_ad_d;
         drv_tm0_q   <= drv_tm0_d;
         drv_tm1_q   <= drv_tm1_d;
         drv_start_q <= drv_start_d;
         drv_rqst_q  <= drv_rqst_d;
         drv_ack_q   <= drv_ack_d;
         drv_arb_q   <= drv_arb_d;
      end
   end

   // open-collector: a logical 1 pulls the line low, a logical 0 releases it
   for (genvar i = 0; i < 32; i++) begin : g_ad
      assign nub_adn[i] = drv_ad_q[i] ? 1'b0 : 1'bz;
   end
   for (genvar i = 0; i < 4; i++) begin : g_arb
      assign nub_arbn[i] = drv_arb_q[i] ? 1'b0 : 1'bz;
   end
   assign nub_tm0n   = drv_tm0_q   ? 1'b0 : 1'bz;
   assign nub_tm1n   = drv_tm1_q   ? 1'b0 : 1'bz;
   assign nub_startn = drv_start_q ? 1'b0 : 1'bz;
   assign nub_rqstn  = drv_rqst_q  ? 1'b0 : 1'bz;
   assign nub_ackn   = drv_ack_q   ? 1'b0 : 1'bz;
   assign nub_nmrqn  = 1'bz;
   assign nub_spn    = 1'bz;
   assign nub_spvn   = 1'bz;

   assign cpu_ready  = cpu_ready_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign mem_valid  = mem_valid_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_myslot = mem_myslot_q;
   assign mem_myexp  = mem_myexp_q;

endmodule

// File: tb/tb_nubus_card_interface.sv
`timescale 1ns/1ps
// Bench for nubus_card_interface: card id 0 talking to its own slot space through a local memory.
// Latency: transfers complete in tens of clocks; every wait is bounded.
// Backpressure: memory answers after 5 wait clocks; CPU holds valid until it sees cpu_ready.
module tb_nubus_card_interface;

   logic        nub_clkn, nub_resetn, nub_pfwn;
   logic [3:0]  nub_idn;
   wire  [31:0] nub_adn;
   wire         nub_tm0n, nub_tm1n, nub_startn, nub_rqstn, nub_ackn;
   wire  [3:0]  nub_arbn;
   wire         nub_nmrqn, nub_spn, nub_spvn;
   logic        mem_valid, mem_ready, mem_myslot, mem_myexp;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        cpu_valid, cpu_lock, cpu_ready;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_wstrb;

   nubus_card_interface #(.ARB_CYCLES(2)) dut (
      .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .nub_idn(nub_idn), .nub_pfwn(nub_pfwn),
      .nub_adn(nub_adn), .nub_tm0n(nub_tm0n), .nub_tm1n(nub_tm1n), .nub_startn(nub_startn),
      .nub_rqstn(nub_rqstn), .nub_ackn(nub_ackn), .nub_arbn(nub_arbn), .nub_nmrqn(nub_nmrqn),
      .nub_spn(nub_spn), .nub_spvn(nub_spvn),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_myslot(mem_myslot), .mem_myexp(mem_myexp),
      .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_lock(cpu_lock), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata)
   );

   // bus pull-ups and a foreign master that can pulse start/ad/ack
   logic        tb_start, tb_ack;
   logic [31:0] tb_ad;
   for (genvar i = 0; i < 32; i++) begin : g_ad
      pullup (nub_adn[i]);
      assign nub_adn[i] = tb_ad[i] ? 1'b0 : 1'bz;
   end
   for (genvar i = 0; i < 4; i++) begin : g_arb
      pullup (nub_arbn[i]);
   end
   pullup (nub_tm0n);
   pullup (nub_tm1n);
   pullup (nub_startn);
   pullup (nub_rqstn);
   pullup (nub_ackn);
   pullup (nub_nmrqn);
   pullup (nub_spn);
   pullup (nub_spvn);
   assign nub_startn = tb_start ? 1'b0 : 1'bz;
   assign nub_ackn   = tb_ack   ? 1'b0 : 1'bz;

   // 100 ns period, 75 high / 25 low
   initial begin
      nub_clkn = 1'b1;
      forever begin
         #75 nub_clkn = 1'b0;
         #25 nub_clkn = 1'b1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // start-cycle table: {tm1, tm0, ad[1], ad[0]}
   function automatic logic [3:0] mode_of(input logic [3:0] s);
      case (s)
         4'b0000: return 4'b0000;
         4'b1111: return 4'b1000;
         4'b0011: return 4'b1001;
         4'b1100: return 4'b1010;
         4'b0001: return 4'b1100;
         4'b0010: return 4'b1101;
         4'b0100: return 4'b1110;
         4'b1000: return 4'b1111;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // reference model: CPU-visible memory, and the expectations of the transfer in flight
   logic [31:0] ref_mem [16];
   logic [31:0] dev_mem [16];
   logic [31:0] exp_addr;
   logic [3:0]  exp_strb, exp_mode;
   int          n_starts = 0;
   int          rqst_cycles = 0;

   // local memory device: 5 wait clocks, then a one-clock ready
   int wcnt = 0;
   initial begin
      for (int i = 0; i < 16; i++) begin dev_mem[i] = '0; ref_mem[i] = '0; end
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge nub_clkn); #1;
         if (mem_ready) begin
            mem_ready = 1'b0;
            check("mem_valid_drop", {31'b0, mem_valid}, 32'd0);
         end else if (mem_valid) begin
            if (wcnt == 5) begin
               wcnt = 0;
               check("mem_addr", mem_addr, {exp_addr[31:2], 2'b00});
               check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
               check("mem_slot", {30'b0, mem_myslot, mem_myexp}, 32'd2);
               if (mem_wstrb != 4'b0000)
                  dev_mem[mem_addr[5:2]] = merge(dev_mem[mem_addr[5:2]], mem_wdata, mem_wstrb);
               mem_rdata = dev_mem[mem_addr[5:2]];
               mem_ready = 1'b1;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // per-cycle protocol compare, sampled mid-cycle after the rising edge
   logic prev_start = 1'b0, prev_ack = 1'b0, prev_ready = 1'b0;
   initial begin
      forever begin
         @(posedge nub_clkn); #5;
         if (!nub_resetn) begin
            prev_start = 1'b0; prev_ack = 1'b0; prev_ready = 1'b0;
         end else begin
            if (!nub_startn) begin
               n_starts++;
               if (!tb_start) begin
                  check("start_addr", {~nub_adn[31:2], 2'b00}, {exp_addr[31:2], 2'b00});
                  check("start_mode", {28'b0, ~nub_tm1n, ~nub_tm0n, ~nub_adn[1:0]}, {28'b0, exp_mode});
               end
            end
            if (prev_start) check("start_width", {31'b0, ~nub_startn}, 32'd0);
            if (prev_ack)   check("ack_width",   {31'b0, ~nub_ackn},   32'd0);
            if (prev_ready) check("ready_width", {31'b0, cpu_ready},   32'd0);
            if (!nub_rqstn) rqst_cycles++;
            prev_start = !nub_startn;
            prev_ack   = !nub_ackn;
            prev_ready = cpu_ready;
         end
      end
   end

   task automatic cpu_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic lk, output logic [31:0] rd);
      logic got;
      int   n, s0;
      @(negedge nub_clkn); #1;
      exp_addr = a; exp_strb = s; exp_mode = mode_of(s);
      cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_lock = lk; cpu_valid = 1'b1;
      s0 = n_starts; got = 1'b0; n = 0; rd = '0;
      while (!got && n < 100) begin
         @(negedge nub_clkn); #1;
         n++;
         if (cpu_ready) begin got = 1'b1; rd = cpu_rdata; end
      end
      // valid was still high at the edge where ready was sampled
      cpu_valid = 1'b0;
      check("xfer_done", {31'b0, got}, 32'd1);
      if (s != 4'b0000) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
      else check("rdata_model", rd, ref_mem[a[5:2]]);
      repeat (4) @(negedge nub_clkn);
      #1;
      check("no_extra_ready", {31'b0, cpu_ready}, 32'd0);
      check("one_start", n_starts - s0, 32'd1);
   endtask

   logic [31:0] rd;
   logic [31:0] b_addr [4] = '{32'hF000000C, 32'hF0000010, 32'hF0000014, 32'hF0000018};
   logic [3:0]  b_strb [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [31:0] b_exp  [4] = '{32'h00000021, 32'h00004300, 32'h00650000, 32'h87000000};

   task automatic check_reset_state(input string tag);
      check({tag, "_lines"}, {23'b0, nub_startn, nub_rqstn, nub_ackn, nub_tm0n, nub_tm1n, nub_arbn}, 32'h1FF);
      check({tag, "_ad"}, nub_adn, 32'hFFFFFFFF);
      check({tag, "_ctl"}, {24'b0, cpu_ready, mem_valid, mem_myslot, mem_myexp, mem_wstrb}, 32'd0);
      check({tag, "_rdata"}, cpu_rdata, 32'd0);
      check({tag, "_maddr"}, mem_addr, 32'd0);
      check({tag, "_mwdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      int n, s0;
      nub_resetn = 1'b0; nub_idn = 4'hF; nub_pfwn = 1'b1;
      tb_start = 1'b0; tb_ack = 1'b0; tb_ad = '0;
      cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; cpu_lock = 1'b0;
      exp_addr = '0; exp_strb = '0; exp_mode = '0;
      repeat (3) @(posedge nub_clkn);
      #10;
      check_reset_state("por");
      nub_resetn = 1'b1;
      repeat (2) @(posedge nub_clkn);

      // word write then read back; a fresh master holds rqst for exactly ARB_CYCLES on a quiet bus
      rqst_cycles = 0;
      cpu_xfer(32'hF0000000, 32'h87654321, 4'b1111, 1'b0, rd);
      check("arb_cycles", rqst_cycles, 32'd2);
      cpu_xfer(32'hF0000000, 32'h0, 4'b0000, 1'b0, rd);
      check("rd_word", rd, 32'h87654321);

      // half-word writes
      cpu_xfer(32'hF0000004, 32'h87654321, 4'b0011, 1'b0, rd);
      cpu_xfer(32'hF0000004, 32'h0, 4'b0000, 1'b0, rd);
      check("rd_half0", rd, 32'h00004321);
      cpu_xfer(32'hF0000008, 32'h87654321, 4'b1100, 1'b0, rd);
      cpu_xfer(32'hF0000008, 32'h0, 4'b0000, 1'b0, rd);
      check("rd_half1", rd, 32'h87650000);

      // byte writes, lane for lane
      for (int i = 0; i < 4; i++) begin
         cpu_xfer(b_addr[i], 32'h87654321, b_strb[i], 1'b0, rd);
         cpu_xfer(b_addr[i], 32'h0, 4'b0000, 1'b0, rd);
         check("rd_byte", rd, b_exp[i]);
      end

      // locked ownership: the follow-up transfer never requests the bus
      cpu_xfer(32'hF0000020, 32'hCAFEF00D, 4'b1111, 1'b1, rd);
      rqst_cycles = 0;
      cpu_xfer(32'hF0000020, 32'h0, 4'b0000, 1'b0, rd);
      check("lock_no_rqst", rqst_cycles, 32'd0);
      check("rd_locked", rd, 32'hCAFEF00D);
      rqst_cycles = 0;
      cpu_xfer(32'hF0000000, 32'h0, 4'b0000, 1'b0, rd);
      check("unlock_rqst", rqst_cycles, 32'd2);
      check("rd_after_unlock", rd, 32'h87654321);

      // reset in the middle of a write data phase
      @(negedge nub_clkn); #1;
      exp_addr = 32'hF000001C; exp_strb = 4'b1111; exp_mode = mode_of(4'b1111);
      cpu_addr = 32'hF000001C; cpu_wdata = 32'h11111111; cpu_wstrb = 4'b1111; cpu_lock = 1'b0;
      cpu_valid = 1'b1;
      s0 = n_starts; n = 0;
      while (n_starts == s0 && n < 50) begin @(posedge nub_clkn); #10; n++; end
      check("rst_start_seen", {31'b0, n_starts != s0}, 32'd1);
      @(posedge nub_clkn); #10;
      check("rst_data_phase", ~nub_adn, 32'h11111111);
      nub_resetn = 1'b0;
      #5;
      check_reset_state("midrst");
      cpu_valid = 1'b0;
      repeat (2) @(posedge nub_clkn);
      #10 nub_resetn = 1'b1;

      // foreign start into another slot's space: no memory request, no ack
      repeat (2) @(posedge nub_clkn);
      #1 tb_ad = 32'hF1000000; tb_start = 1'b1;
      @(posedge nub_clkn);
      #1 tb_ad = '0; tb_start = 1'b0;
      repeat (12) begin
         @(negedge nub_clkn); #1;
         check("dec_mem_valid", {31'b0, mem_valid}, 32'd0);
         check("dec_no_ack", {31'b0, nub_ackn}, 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
